// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM encoding, scan positions and segment table for seg_scan_ctrl
package seg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV1,
    ST_CONV2,
    ST_COMMIT
  } state_t;

  localparam logic [2:0] POS_P1_TENS  = 3'd1;
  localparam logic [2:0] POS_P1_UNITS = 3'd2;
  localparam logic [2:0] POS_P2_TENS  = 3'd5;
  localparam logic [2:0] POS_P2_UNITS = 3'd6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; element 9 is listed first.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [7:0] anode_sel_n(input logic [2:0] pos);
    return ~(8'h01 << pos);
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// rtl/seg_digit_decode.sv - combinational BCD digit to active-low seven-segment decoder
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) begin
      seg = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - two-player score display: binary-to-BCD conversion FSM and 8-digit scan
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic [5:0] wins1,
  input  logic [5:0] wins2,
  input  logic       upd_req,
  output logic       upd_ack,
  output logic       busy,
  output logic [7:0] anode,
  output logic [6:0] segment
);

  localparam int PRES_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRES_W-1:0] pres_q, pres_d;
  logic [2:0]        idx_q, idx_d;
  state_t            state_q, state_d;
  logic [5:0]        rem1_q, rem1_d, rem2_q, rem2_d;
  logic [2:0]        tens1_q, tens1_d, tens2_q, tens2_d;
  logic [2:0]        disp_t1_q, disp_t1_d, disp_t2_q, disp_t2_d;
  logic [3:0]        disp_u1_q, disp_u1_d, disp_u2_q, disp_u2_d;
  logic              upd_ack_q, upd_ack_d, busy_q, busy_d;
  logic [7:0]        anode_q, anode_d;
  logic [6:0]        segment_q, segment_d;

  logic              tick;
  logic [3:0]        dec_digit;
  logic              dec_blank;
  logic [6:0]        dec_seg;
  logic [7:0]        an_sel;

  assign tick = (pres_q == PRES_W'(SCAN_DIV - 1));

  always_comb begin
    pres_d = tick ? '0 : pres_q + PRES_W'(1);
    idx_d  = tick ? idx_q + 3'd1 : idx_q;
  end

  // Digit selection looks at the index being entered so the registered outputs track it.
  always_comb begin
    dec_digit = 4'd0;
    dec_blank = 1'b1;
    an_sel    = 8'hFF;
    case (idx_d)
      POS_P1_TENS: begin
        dec_digit = {1'b0, disp_t1_q};
        dec_blank = LZ_BLANK && (disp_t1_q == 3'd0);
        an_sel    = anode_sel_n(idx_d);
      end
      POS_P1_UNITS: begin
        dec_digit = disp_u1_q;
        dec_blank = 1'b0;
        an_sel    = anode_sel_n(idx_d);
      end
      POS_P2_TENS: begin
        dec_digit = {1'b0, disp_t2_q};
        dec_blank = LZ_BLANK && (disp_t2_q == 3'd0);
        an_sel    = anode_sel_n(idx_d);
      end
      POS_P2_UNITS: begin
        dec_digit = disp_u2_q;
        dec_blank = 1'b0;
        an_sel    = anode_sel_n(idx_d);
      end
      default: ;
    endcase
  end

  seg_digit_decode u_decode (
    .digit (dec_digit),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    anode_d   = tick ? an_sel : anode_q;
    segment_d = tick ? dec_seg : segment_q;
  end

  // Conversion by repeated subtraction of 10; display registers change only in COMMIT.
  always_comb begin
    state_d   = state_q;
    rem1_d    = rem1_q;
    rem2_d    = rem2_q;
    tens1_d   = tens1_q;
    tens2_d   = tens2_q;
    disp_t1_d = disp_t1_q;
    disp_u1_d = disp_u1_q;
    disp_t2_d = disp_t2_q;
    disp_u2_d = disp_u2_q;
    upd_ack_d = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (upd_req) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        rem1_d  = wins1;
        rem2_d  = wins2;
        tens1_d = 3'd0;
        tens2_d = 3'd0;
        state_d = ST_CONV1;
      end
      ST_CONV1: begin
        if (rem1_q >= 6'd10) begin
          rem1_d  = rem1_q - 6'd10;
          tens1_d = tens1_q + 3'd1;
        end else begin
          state_d = ST_CONV2;
        end
      end
      ST_CONV2: begin
        if (rem2_q >= 6'd10) begin
          rem2_d  = rem2_q - 6'd10;
          tens2_d = tens2_q + 3'd1;
        end else begin
          state_d   = ST_COMMIT;
          upd_ack_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        disp_t1_d = tens1_q;
        disp_u1_d = rem1_q[3:0];
        disp_t2_d = tens2_q;
        disp_u2_d = rem2_q[3:0];
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      pres_q    <= '0;
      idx_q     <= 3'd0;
      state_q   <= ST_IDLE;
      rem1_q    <= 6'd0;
      rem2_q    <= 6'd0;
      tens1_q   <= 3'd0;
      tens2_q   <= 3'd0;
      disp_t1_q <= 3'd0;
      disp_u1_q <= 4'd0;
      disp_t2_q <= 3'd0;
      disp_u2_q <= 4'd0;
      upd_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      anode_q   <= 8'hFF;
      segment_q <= SEG_BLANK;
    end else begin
      pres_q    <= pres_d;
      idx_q     <= idx_d;
      state_q   <= state_d;
      rem1_q    <= rem1_d;
      rem2_q    <= rem2_d;
      tens1_q   <= tens1_d;
      tens2_q   <= tens2_d;
      disp_t1_q <= disp_t1_d;
      disp_u1_q <= disp_u1_d;
      disp_t2_q <= disp_t2_d;
      disp_u2_q <= disp_u2_d;
      upd_ack_q <= upd_ack_d;
      busy_q    <= busy_d;
      anode_q   <= anode_d;
      segment_q <= segment_d;
    end
  end

  assign upd_ack = upd_ack_q;
  assign busy    = busy_q;
  assign anode   = anode_q;
  assign segment = segment_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with a transaction-level display model
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] wins1, wins2;
  logic       upd_req;
  logic       upd_ack, busy;
  logic [7:0] anode;
  logic [6:0] segment;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .LZ_BLANK(1'b1)) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .wins1      (wins1),
    .wins2      (wins2),
    .upd_req    (upd_req),
    .upd_ack    (upd_ack),
    .busy       (busy),
    .anode      (anode),
    .segment    (segment)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Display model: scores as decimal digits, scan as a position counter.
  logic [6:0] seg_lut [10];
  initial begin
    seg_lut[0] = 7'h40; seg_lut[1] = 7'h79; seg_lut[2] = 7'h24; seg_lut[3] = 7'h30;
    seg_lut[4] = 7'h19; seg_lut[5] = 7'h12; seg_lut[6] = 7'h02; seg_lut[7] = 7'h78;
    seg_lut[8] = 7'h00; seg_lut[9] = 7'h10;
  end

  function automatic logic [6:0] digit_seg(input int d, input bit is_tens);
    if (is_tens && d == 0) return 7'h7F;
    return seg_lut[d];
  endfunction

  int         m_pres, m_idx, m_age, m_len, m_w1, m_w2;
  int         m_t1, m_u1, m_t2, m_u2;
  bit         m_busy, m_ack, cmp_en = 1'b0;
  logic [7:0] m_anode;
  logic [6:0] m_seg;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pres = 0; m_idx = 0; m_busy = 0; m_ack = 0; m_age = 0; m_len = 0;
      m_t1 = 0; m_u1 = 0; m_t2 = 0; m_u2 = 0;
      m_anode = 8'hFF; m_seg = 7'h7F;
    end else begin
      if (m_pres == SCAN_DIV - 1) begin
        m_pres = 0;
        m_idx  = (m_idx + 1) % 8;
        case (m_idx)
          1: begin m_anode = 8'hFD; m_seg = digit_seg(m_t1, 1); end
          2: begin m_anode = 8'hFB; m_seg = digit_seg(m_u1, 0); end
          5: begin m_anode = 8'hDF; m_seg = digit_seg(m_t2, 1); end
          6: begin m_anode = 8'hBF; m_seg = digit_seg(m_u2, 0); end
          default: begin m_anode = 8'hFF; m_seg = 7'h7F; end
        endcase
      end else begin
        m_pres++;
      end
      m_ack = 0;
      if (!m_busy) begin
        if (upd_req) begin m_busy = 1; m_age = 0; end
      end else begin
        m_age++;
        if (m_age == 1) begin
          m_w1 = int'(wins1); m_w2 = int'(wins2);
          m_len = 3 + m_w1 / 10 + m_w2 / 10;
        end
        if (m_age == m_len) m_ack = 1;
        else if (m_age == m_len + 1) begin
          m_t1 = m_w1 / 10; m_u1 = m_w1 % 10;
          m_t2 = m_w2 / 10; m_u2 = m_w2 % 10;
          m_busy = 0;
        end
      end
    end
    cmp_en = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_anode", 32'(anode), 32'(m_anode));
      check("cyc_segment", 32'(segment), 32'(m_seg));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_upd_ack", 32'(upd_ack), 32'(m_ack));
      check("cyc_anode_onehot", 32'($countones(~anode) <= 1), 32'd1);
    end
  end

  logic [6:0] cap [8];

  task automatic observe_scan(input int cycles);
    for (int p = 0; p < 8; p++) cap[p] = 7'h55;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      case (anode)
        8'hFD: cap[1] = segment;
        8'hFB: cap[2] = segment;
        8'hDF: cap[5] = segment;
        8'hBF: cap[6] = segment;
        default: ;
      endcase
    end
  endtask

  task automatic run_conv(input logic [5:0] w1, input logic [5:0] w2, output int lat, output int blen);
    bit got;
    got = 0; lat = -1; blen = 0;
    @(negedge clk);
    wins1 = w1; wins2 = w2; upd_req = 1'b1;
    @(posedge clk); #1;
    upd_req = 1'b0;
    if (busy) blen++;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (busy) blen++;
      if (upd_ack && !got) begin got = 1; lat = k; end
      if (!busy) break;
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s5, input logic [6:0] s6);
    observe_scan(40);
    check({tag, "_p1_tens"}, 32'(cap[1]), 32'(s1));
    check({tag, "_p1_units"}, 32'(cap[2]), 32'(s2));
    check({tag, "_p2_tens"}, 32'(cap[5]), 32'(s5));
    check({tag, "_p2_units"}, 32'(cap[6]), 32'(s6));
  endtask

  initial begin
    int lat, blen, acks_seen, found;
    int acks[$];
    rst_n = 1'b0; upd_req = 1'b0; wins1 = 6'd0; wins2 = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_anode", 32'(anode), 32'hFF);
    check("reset_segment", 32'(segment), 32'h7F);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(upd_ack), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("pretick_anode", 32'(anode), 32'hFF);

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (anode == 8'hFB) found = 1;
    end
    check("idx2_anode", 32'(anode), 32'hFB);
    check("idx2_segment", 32'(segment), 32'h40);

    run_conv(6'd37, 6'd5, lat, blen);
    check("ack_lat_37_5", 32'(lat), 32'd6);
    check("busy_len_37_5", 32'(blen), 32'd7);
    check_digits("d37_5", 7'h30, 7'h78, 7'h7F, 7'h12);

    run_conv(6'd63, 6'd63, lat, blen);
    check("ack_lat_63_63", 32'(lat), 32'd15);
    check("busy_len_63_63", 32'(blen), 32'd16);
    check_digits("d63_63", 7'h02, 7'h30, 7'h02, 7'h30);

    run_conv(6'd9, 6'd10, lat, blen);
    check("ack_lat_9_10", 32'(lat), 32'd4);
    check_digits("d9_10", 7'h7F, 7'h10, 7'h79, 7'h40);

    // Held request; scores change during the first conversion and must not leak into it.
    @(negedge clk);
    wins1 = 6'd12; wins2 = 6'd34; upd_req = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin wins1 = 6'd45; wins2 = 6'd6; end
      if (upd_ack) acks.push_back(k);
    end
    upd_req = 1'b0;
    check("held_ack_count", 32'(acks.size()), 32'd3);
    while (acks.size() < 3) acks.push_back(-100);
    check("held_ack0", 32'(acks[0]), 32'd7);
    check("held_gap1", 32'(acks[1] - acks[0]), 32'd9);
    check("held_gap2", 32'(acks[2] - acks[1]), 32'd9);
    repeat (20) @(posedge clk);
    check_digits("d45_6", 7'h19, 7'h12, 7'h7F, 7'h02);

    // Reset in the middle of converting 50.
    @(negedge clk);
    wins1 = 6'd50; wins2 = 6'd0; upd_req = 1'b1;
    @(posedge clk); #1;
    upd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("conv1_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_anode", 32'(anode), 32'hFF);
    acks_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (upd_ack) acks_seen++;
    end
    check("abort_no_ack", 32'(acks_seen), 32'd0);
    check_digits("abort_zero", 7'h7F, 7'h40, 7'h7F, 7'h40);

    run_conv(6'd50, 6'd0, lat, blen);
    check("ack_lat_50_0", 32'(lat), 32'd8);
    check_digits("d50_0", 7'h12, 7'h40, 7'h7F, 7'h40);

    repeat (80) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
